// File: rtl/hash_msg_feeder_if.sv
// Byte-input handshake between the message feeder and the hash core.
// The feeder drives bytes and framing; the core returns flow control and the digest.
interface hash_msg_feeder_if #(
   parameter int unsigned DIG_W = 64
);
   logic             hash_start;
   logic             hash_F_dr;
   logic [7:0]       hash_M;
   logic             hash_F_rtr;
   logic             hash_eof;
   logic             hash_H_ready;
   logic [DIG_W-1:0] hash_digest;

   modport master (
      output hash_start, hash_F_dr, hash_M, hash_eof,
      input  hash_F_rtr, hash_H_ready, hash_digest
   );

   modport slave (
      input  hash_start, hash_F_dr, hash_M, hash_eof,
      output hash_F_rtr, hash_H_ready, hash_digest
   );
endinterface

// File: rtl/hash_msg_feeder.sv
// Feeds a length-framed byte message through a small FIFO into the hash core,
// then captures the digest and offers it downstream, with a watchdog on the core.
module hash_msg_feeder #(
   parameter int unsigned LEN_W       = 16,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned DIG_W       = 64,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_start,
   input  logic [LEN_W-1:0]    msg_len,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   output logic                in_ready,
   hash_msg_feeder_if.master   hash,
   output logic                dig_valid,
   output logic [DIG_W-1:0]    dig_data,
   input  logic                dig_ack,
   output logic                busy,
   output logic                err_timeout
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {StIdle, StStart, StSend, StEof, StWaitH, StHold} state_e;

   state_e           state_q;
   logic [LEN_W-1:0] acc_rem_q;
   logic [LEN_W-1:0] tx_rem_q;
   logic [WD_W-1:0]  wd_q;
   logic             err_q;
   logic [DIG_W-1:0] dig_data_q;
   logic [7:0]       fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr_q;
   logic [PTR_W:0]   rd_ptr_q;

   logic [PTR_W:0] fifo_count;
   logic           fifo_empty;
   logic           fifo_full;
   logic           push;
   logic           pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));

   assign in_ready = ((state_q == StStart) || (state_q == StSend)) && !fifo_full &&
                     (acc_rem_q != '0);
   assign push     = in_valid && in_ready;

   assign hash.hash_start = (state_q == StStart);
   assign hash.hash_F_dr  = (state_q == StSend) && !fifo_empty;
   assign hash.hash_M     = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign hash.hash_eof   = (state_q == StEof);
   assign pop             = hash.hash_F_dr && hash.hash_F_rtr;

   assign dig_valid   = (state_q == StHold);
   assign dig_data    = dig_data_q;
   assign busy        = (state_q != StIdle);
   assign err_timeout = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         acc_rem_q  <= '0;
         tx_rem_q   <= '0;
         wd_q       <= '0;
         err_q      <= 1'b0;
         dig_data_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= in_data;
            wr_ptr_q  <= wr_ptr_q + (PTR_W + 1)'(1);
            acc_rem_q <= acc_rem_q - LEN_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            tx_rem_q <= tx_rem_q - LEN_W'(1);
         end

         unique case (state_q)
            StIdle: begin
               if (cmd_start) begin
                  acc_rem_q <= msg_len;
                  tx_rem_q  <= msg_len;
                  err_q     <= 1'b0;
                  state_q   <= StStart;
               end
            end
            StStart: begin
               state_q <= (tx_rem_q != '0) ? StSend : StEof;
            end
            StSend: begin
               if (pop && (tx_rem_q == LEN_W'(1))) begin
                  state_q <= StEof;
               end
            end
            StEof: begin
               wd_q    <= '0;
               state_q <= StWaitH;
            end
            StWaitH: begin
               if (hash.hash_H_ready) begin
                  dig_data_q <= hash.hash_digest;
                  state_q    <= StHold;
               end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            StHold: begin
               if (dig_ack) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
